// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states,
// byte-enable generation and load-result extension.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // size is funct3[1:0]; lo is addr[1:0]
    function automatic logic [3:0] be_from_f3(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                                input logic [1:0] lo);
        logic [31:0] sh;
        sh = word >> {lo, 3'b000};
        case (f3)
            F3_LB:   return {{24{sh[7]}}, sh[7:0]};
            F3_LH:   return {{16{sh[15]}}, sh[15:0]};
            F3_LW:   return sh;
            F3_LBU:  return {24'h0, sh[7:0]};
            F3_LHU:  return {16'h0, sh[15:0]};
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the core (master) and the load/store unit (slave).
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lsu_ram.sv
// Single-port byte-enabled data RAM: synchronous write, registered read on the same edge.
module dmem_lsu_ram #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           i_we,
    input  logic                           i_re,
    input  logic [3:0]                     i_be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
    input  logic [31:0]                    i_wdata,
    output logic [31:0]                    o_rdata
);
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit for RV32I data accesses: valid/ready request, configurable
// response latency, byte/half/word stores and sign/zero-extended loads.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYC    = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    dmem_lsu_if.slave bus
);
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(64'(DEPTH_WORDS) * 64'd4);
    localparam logic [2:0]  CNT_INIT = (WAIT_CYC == 0) ? 3'd0 : 3'(WAIT_CYC - 1);

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic        w_ready, w_acc;
    logic [31:0] w_off;
    logic        w_oor, w_misal, w_illegal, w_err;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_lanes;
    logic        w_ram_we, w_ram_re;
    logic [31:0] w_ram_rdata;

    logic        r_we_p1;
    logic        r_err_p1;
    logic [2:0]  r_f3_p1;
    logic [1:0]  r_alo_p1;

    assign w_ready = (r_state != WAIT);
    assign w_acc   = bus.req_valid && w_ready;

    // Stage p0: request decode and checks at the accept edge
    assign w_off = bus.req_addr - BASE_ADDR;
    assign w_oor = (bus.req_addr < BASE_ADDR) || ({1'b0, w_off} >= SPAN);

    always_comb begin
        w_misal = 1'b0;
        case (bus.req_funct3[1:0])
            2'b01:   w_misal = bus.req_addr[0];
            2'b10:   w_misal = |bus.req_addr[1:0];
            default: w_misal = 1'b0;
        endcase
    end

    assign w_illegal = bus.req_we ? (bus.req_funct3 > F3_SW)
                                  : ((bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11));
    assign w_err     = w_oor || w_misal || w_illegal;

    // Replicate store data across lanes so the byte enables pick the right copy
    always_comb begin
        case (bus.req_funct3[1:0])
            2'b00:   w_wdata_lanes = {4{bus.req_wdata[7:0]}};
            2'b01:   w_wdata_lanes = {2{bus.req_wdata[15:0]}};
            default: w_wdata_lanes = bus.req_wdata;
        endcase
    end

    assign w_be     = be_from_f3(bus.req_funct3[1:0], bus.req_addr[1:0]);
    assign w_ram_we = rst_n && w_acc && bus.req_we && !w_err;
    assign w_ram_re = w_acc && !bus.req_we && !w_err;

    dmem_lsu_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_ram_we),
        .i_re   (w_ram_re),
        .i_be   (w_be),
        .i_addr (w_off[AW+1:2]),
        .i_wdata(w_wdata_lanes),
        .o_rdata(w_ram_rdata)
    );

    // Stage p1: captured request attributes held until the response
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_we_p1  <= bus.req_we;
            r_err_p1 <= w_err;
            r_f3_p1  <= bus.req_funct3;
            r_alo_p1 <= bus.req_addr[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE, RESP: begin
                w_state_nxt = IDLE;
                if (w_acc) begin
                    w_state_nxt = (WAIT_CYC == 0) ? RESP : WAIT;
                    w_cnt_nxt   = CNT_INIT;
                end
            end
            WAIT: begin
                if (r_cnt == 3'd0) w_state_nxt = RESP;
                else               w_cnt_nxt   = r_cnt - 3'd1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_err   = (r_state == RESP) && r_err_p1;
    assign bus.rsp_rdata = ((r_state == RESP) && !r_we_p1 && !r_err_p1)
                           ? load_extend(r_f3_p1, w_ram_rdata, r_alo_p1) : 32'h0;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: one zero-wait instance and one three-wait instance
// with a non-zero base address, exercised by one task per scenario.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    logic clk;
    logic rst_n0;
    logic rst_n3;
    int   cyc;
    int   n_vec;
    int   n_err;

    dmem_lsu_if if0();
    dmem_lsu_if if3();

    dmem_lsu #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYC(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n0), .bus(if0)
    );
    dmem_lsu #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_2000), .WAIT_CYC(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n3), .bus(if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
        if0.req_valid = v; if0.req_we = we; if0.req_funct3 = f3;
        if0.req_addr = a; if0.req_wdata = d;
    endtask

    task automatic drv3(input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
        if3.req_valid = v; if3.req_we = we; if3.req_funct3 = f3;
        if3.req_addr = a; if3.req_wdata = d;
    endtask

    task automatic test_reset();
        drv0(0, 0, 3'b000, 32'h0, 32'h0);
        drv3(0, 0, 3'b000, 32'h0, 32'h0);
        rst_n0 = 1'b0; rst_n3 = 1'b0;
        repeat (2) tick();
        n_vec++; if (if0.req_ready !== 1'b1) begin n_err++; $display("FAIL rst0_ready: got %b exp 1", if0.req_ready); end
        n_vec++; if (if0.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst0_valid: got %b exp 0", if0.rsp_valid); end
        n_vec++; if (if0.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL rst0_rdata: got %h exp 0", if0.rsp_rdata); end
        n_vec++; if (if0.rsp_err !== 1'b0) begin n_err++; $display("FAIL rst0_err: got %b exp 0", if0.rsp_err); end
        n_vec++; if (if3.req_ready !== 1'b1) begin n_err++; $display("FAIL rst3_ready: got %b exp 1", if3.req_ready); end
        n_vec++; if (if3.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst3_valid: got %b exp 0", if3.rsp_valid); end
        rst_n0 = 1'b1; rst_n3 = 1'b1;
        tick();
        n_vec++; if (if0.rsp_valid !== 1'b0) begin n_err++; $display("FAIL idle0_valid: got %b exp 0", if0.rsp_valid); end
    endtask

    task automatic test_word_access();
        drv0(1, 1, F3_SW, 32'h10, 32'hDEADBEEF);
        n_vec++; if (if0.req_ready !== 1'b1) begin n_err++; $display("FAIL sw_ready: got %b exp 1", if0.req_ready); end
        tick();
        n_vec++; if (if0.rsp_valid !== 1'b1) begin n_err++; $display("FAIL sw_valid: got %b exp 1", if0.rsp_valid); end
        n_vec++; if (if0.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL sw_rdata: got %h exp 0", if0.rsp_rdata); end
        n_vec++; if (if0.req_ready !== 1'b1) begin n_err++; $display("FAIL sw_b2b_ready: got %b exp 1", if0.req_ready); end
        drv0(1, 0, F3_LW, 32'h10, 32'h0);
        tick();
        n_vec++; if (if0.rsp_valid !== 1'b1) begin n_err++; $display("FAIL lw_valid: got %b exp 1", if0.rsp_valid); end
        n_vec++; if (if0.rsp_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_rdata: got %h exp deadbeef", if0.rsp_rdata); end
        n_vec++; if (if0.rsp_err !== 1'b0) begin n_err++; $display("FAIL lw_err: got %b exp 0", if0.rsp_err); end
        drv0(0, 0, F3_LW, 32'h10, 32'h0);
        tick();
        n_vec++; if (if0.rsp_valid !== 1'b0) begin n_err++; $display("FAIL lw_pulse: got %b exp 0", if0.rsp_valid); end
    endtask

    task automatic test_subword();
        drv0(1, 1, F3_SB, 32'h11, 32'h0000_0080);
        tick();
        n_vec++; if (if0.rsp_err !== 1'b0) begin n_err++; $display("FAIL sb_err: got %b exp 0", if0.rsp_err); end
        drv0(1, 0, F3_LB, 32'h11, 32'h0);
        tick();
        n_vec++; if (if0.rsp_rdata !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_rdata: got %h exp ffffff80", if0.rsp_rdata); end
        drv0(1, 0, F3_LBU, 32'h11, 32'h0);
        tick();
        n_vec++; if (if0.rsp_rdata !== 32'h00000080) begin n_err++; $display("FAIL lbu_rdata: got %h exp 00000080", if0.rsp_rdata); end
        drv0(1, 0, F3_LW, 32'h10, 32'h0);
        tick();
        n_vec++; if (if0.rsp_rdata !== 32'hDEAD80EF) begin n_err++; $display("FAIL sb_merge: got %h exp dead80ef", if0.rsp_rdata); end
        drv0(1, 1, F3_SH, 32'h12, 32'h0000_8001);
        tick();
        n_vec++; if (if0.rsp_valid !== 1'b1) begin n_err++; $display("FAIL sh_valid: got %b exp 1", if0.rsp_valid); end
        drv0(1, 0, F3_LH, 32'h12, 32'h0);
        tick();
        n_vec++; if (if0.rsp_rdata !== 32'hFFFF8001) begin n_err++; $display("FAIL lh_rdata: got %h exp ffff8001", if0.rsp_rdata); end
        drv0(1, 0, F3_LHU, 32'h12, 32'h0);
        tick();
        n_vec++; if (if0.rsp_rdata !== 32'h00008001) begin n_err++; $display("FAIL lhu_rdata: got %h exp 00008001", if0.rsp_rdata); end
        drv0(1, 0, F3_LH, 32'h10, 32'h0);
        tick();
        n_vec++; if (if0.rsp_rdata !== 32'hFFFF80EF) begin n_err++; $display("FAIL lh_low: got %h exp ffff80ef", if0.rsp_rdata); end
        drv0(0, 0, F3_LB, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_misaligned();
        drv0(1, 0, F3_LH, 32'h13, 32'h0);
        tick();
        n_vec++; if (if0.rsp_err !== 1'b1) begin n_err++; $display("FAIL lh_mis_err: got %b exp 1", if0.rsp_err); end
        n_vec++; if (if0.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL lh_mis_rdata: got %h exp 0", if0.rsp_rdata); end
        drv0(1, 1, F3_SW, 32'h12, 32'h12345678);
        tick();
        n_vec++; if (if0.rsp_err !== 1'b1) begin n_err++; $display("FAIL sw_mis_err: got %b exp 1", if0.rsp_err); end
        drv0(1, 1, F3_SH, 32'h11, 32'h0000_5555);
        tick();
        n_vec++; if (if0.rsp_err !== 1'b1) begin n_err++; $display("FAIL sh_mis_err: got %b exp 1", if0.rsp_err); end
        drv0(1, 0, F3_LW, 32'h10, 32'h0);
        tick();
        n_vec++; if (if0.rsp_rdata !== 32'h800180EF) begin n_err++; $display("FAIL mis_nowrite: got %h exp 800180ef", if0.rsp_rdata); end
        drv0(0, 0, F3_LB, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_range_funct3();
        drv0(1, 1, F3_SW, 32'h0, 32'h11223344);
        tick();
        n_vec++; if (if0.rsp_err !== 1'b0) begin n_err++; $display("FAIL sw0_err: got %b exp 0", if0.rsp_err); end
        drv0(1, 1, F3_SW, 32'h1000, 32'hFFFFFFFF);
        tick();
        n_vec++; if (if0.rsp_err !== 1'b1) begin n_err++; $display("FAIL oor_err: got %b exp 1", if0.rsp_err); end
        drv0(1, 0, 3'b011, 32'h10, 32'h0);
        tick();
        n_vec++; if (if0.rsp_err !== 1'b1) begin n_err++; $display("FAIL ld011_err: got %b exp 1", if0.rsp_err); end
        n_vec++; if (if0.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL ld011_rdata: got %h exp 0", if0.rsp_rdata); end
        drv0(1, 0, 3'b110, 32'h10, 32'h0);
        tick();
        n_vec++; if (if0.rsp_err !== 1'b1) begin n_err++; $display("FAIL ld110_err: got %b exp 1", if0.rsp_err); end
        drv0(1, 1, 3'b011, 32'h0, 32'h0);
        tick();
        n_vec++; if (if0.rsp_err !== 1'b1) begin n_err++; $display("FAIL st011_err: got %b exp 1", if0.rsp_err); end
        drv0(1, 0, F3_LW, 32'h0, 32'h0);
        tick();
        n_vec++; if (if0.rsp_rdata !== 32'h11223344) begin n_err++; $display("FAIL word0_intact: got %h exp 11223344", if0.rsp_rdata); end
        drv0(1, 1, F3_SW, 32'hFFC, 32'hCAFEF00D);
        tick();
        n_vec++; if (if0.rsp_err !== 1'b0) begin n_err++; $display("FAIL lastw_err: got %b exp 0", if0.rsp_err); end
        drv0(1, 0, F3_LW, 32'hFFC, 32'h0);
        tick();
        n_vec++; if (if0.rsp_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL lastw_rdata: got %h exp cafef00d", if0.rsp_rdata); end
        drv0(0, 0, F3_LB, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_wait_latency();
        int acc;
        drv3(1, 1, F3_SW, 32'h2004, 32'h0BADF00D);
        tick();
        drv3(0, 0, F3_LB, 32'h0, 32'h0);
        n_vec++; if (if3.req_ready !== 1'b0) begin n_err++; $display("FAIL w_sw_ready: got %b exp 0", if3.req_ready); end
        repeat (3) tick();
        n_vec++; if (if3.rsp_valid !== 1'b1) begin n_err++; $display("FAIL w_sw_valid: got %b exp 1", if3.rsp_valid); end
        drv3(1, 0, F3_LW, 32'h2004, 32'h0);
        acc = cyc;
        tick();
        // Pending request during WAIT must not be taken
        drv3(1, 1, F3_SW, 32'h2004, 32'hFFFFFFFF);
        for (int i = 1; i <= 3; i++) begin
            n_vec++; if (if3.req_ready !== 1'b0) begin n_err++; $display("FAIL w_ready_c%0d: got %b exp 0", i, if3.req_ready); end
            n_vec++; if (if3.rsp_valid !== 1'b0) begin n_err++; $display("FAIL w_valid_c%0d: got %b exp 0", i, if3.rsp_valid); end
            if (i < 3) tick();
        end
        drv3(0, 0, F3_LB, 32'h0, 32'h0);
        tick();
        n_vec++; if (cyc - acc !== 4) begin n_err++; $display("FAIL w_latency: got %0d exp 4", cyc - acc); end
        n_vec++; if (if3.rsp_valid !== 1'b1) begin n_err++; $display("FAIL w_lw_valid: got %b exp 1", if3.rsp_valid); end
        n_vec++; if (if3.rsp_rdata !== 32'h0BADF00D) begin n_err++; $display("FAIL w_lw_rdata: got %h exp 0badf00d", if3.rsp_rdata); end
        n_vec++; if (if3.req_ready !== 1'b1) begin n_err++; $display("FAIL w_resp_ready: got %b exp 1", if3.req_ready); end
        drv3(1, 0, F3_LH, 32'h2004, 32'h0);
        tick();
        drv3(0, 0, F3_LB, 32'h0, 32'h0);
        n_vec++; if (if3.req_ready !== 1'b0) begin n_err++; $display("FAIL w_b2b_acc: got %b exp 0", if3.req_ready); end
        repeat (3) tick();
        n_vec++; if (if3.rsp_rdata !== 32'hFFFFF00D) begin n_err++; $display("FAIL w_lh_rdata: got %h exp fffff00d", if3.rsp_rdata); end
        tick();
        n_vec++; if (if3.rsp_valid !== 1'b0) begin n_err++; $display("FAIL w_pulse: got %b exp 0", if3.rsp_valid); end
        drv3(1, 1, F3_SW, 32'h1FFC, 32'h0);
        tick();
        drv3(0, 0, F3_LB, 32'h0, 32'h0);
        repeat (3) tick();
        n_vec++; if (if3.rsp_err !== 1'b1) begin n_err++; $display("FAIL w_below_base: got %b exp 1", if3.rsp_err); end
        drv3(1, 0, F3_LW, 32'h2400, 32'h0);
        tick();
        drv3(0, 0, F3_LB, 32'h0, 32'h0);
        repeat (3) tick();
        n_vec++; if (if3.rsp_err !== 1'b1) begin n_err++; $display("FAIL w_above_top: got %b exp 1", if3.rsp_err); end
        tick();
    endtask

    task automatic test_reset_midflight();
        logic seen;
        drv3(1, 0, F3_LW, 32'h2004, 32'h0);
        tick();
        drv3(0, 0, F3_LB, 32'h0, 32'h0);
        rst_n3 = 1'b0;
        tick();
        rst_n3 = 1'b1;
        n_vec++; if (if3.req_ready !== 1'b1) begin n_err++; $display("FAIL mr_ready: got %b exp 1", if3.req_ready); end
        n_vec++; if (if3.rsp_valid !== 1'b0) begin n_err++; $display("FAIL mr_valid: got %b exp 0", if3.rsp_valid); end
        n_vec++; if (if3.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL mr_rdata: got %h exp 0", if3.rsp_rdata); end
        n_vec++; if (if3.rsp_err !== 1'b0) begin n_err++; $display("FAIL mr_err: got %b exp 0", if3.rsp_err); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (if3.rsp_valid === 1'b1) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL mr_dropped: got %b exp 0", seen); end
        drv3(1, 0, F3_LW, 32'h2004, 32'h0);
        tick();
        drv3(0, 0, F3_LB, 32'h0, 32'h0);
        repeat (3) tick();
        n_vec++; if (if3.rsp_valid !== 1'b1) begin n_err++; $display("FAIL mr_post_valid: got %b exp 1", if3.rsp_valid); end
        n_vec++; if (if3.rsp_rdata !== 32'h0BADF00D) begin n_err++; $display("FAIL mr_intact: got %h exp 0badf00d", if3.rsp_rdata); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_n0 = 1'b0;
        rst_n3 = 1'b0;
        drv0(0, 0, 3'b000, 32'h0, 32'h0);
        drv3(0, 0, 3'b000, 32'h0, 32'h0);
        tick();
        test_reset();
        test_word_access();
        test_subword();
        test_misaligned();
        test_range_funct3();
        test_wait_latency();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
